// File: rtl/muldiv_sched.sv
// Scheduler for the shared HI/LO multiplier/divider of a dual-issue execute stage.
// Optional build macro MULDIV_FASTZERO_EN: zero-operand ops complete without using a unit.
module muldiv_sched #(
  parameter int unsigned WATCHDOG = 64
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [5:0]   op_i,
  input  logic [63:0]  a_i,
  input  logic [63:0]  b_i,
  input  logic         flush_i,
  input  logic         stall_i,
  output logic         mul_valid_o,
  output logic         div_valid_o,
  output logic [31:0]  unit_a_o,
  output logic [31:0]  unit_b_o,
  input  logic         mul_done_i,
  input  logic [63:0]  mul_c_i,
  input  logic         div_done_i,
  input  logic [63:0]  div_c_i,
  output logic [127:0] hilo_o,
  output logic [1:0]   hilo_vld_o,
  output logic         e_wait,
  output logic         wd_err_o
);

  localparam int unsigned CW = (WATCHDOG > 1) ? $clog2(WATCHDOG) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_e;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == 3'd1) || (op == 3'd2);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == 3'd3) || (op == 3'd4);
  endfunction

  function automatic logic is_sgn(input logic [2:0] op);
    return (op == 3'd1) || (op == 3'd3);
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

`ifdef MULDIV_FASTZERO_EN
  function automatic logic fast_zero(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    return (is_mul(op) && ((a == '0) || (b == '0))) || (is_div(op) && (a == '0));
  endfunction
`endif

  state_e         state_q, state_d;
  logic           cur_q, cur_d;
  logic [1:0]     pend_q, pend_d;
  logic [5:0]     op_q, op_d;
  logic [63:0]    a_q, a_d, b_q, b_d;
  logic [127:0]   hilo_q, hilo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           wd_err_q, wd_err_d;

  logic [1:0]     pend_in;
  logic [2:0]     cur_op;
  logic [31:0]    cur_a, cur_b;
  logic           sel_done;
  logic [31:0]    quo, rem;
  logic [63:0]    fixed_res;
`ifdef MULDIV_FASTZERO_EN
  logic [2:0]     idle_op;
  logic [31:0]    idle_a, idle_b;
`endif

  // Slot s lives at op_i[3s+2:3s], a_i/b_i[32s+31:32s]; slot 1 is the older instruction.
  always_comb begin
    pend_in  = {is_mul(op_i[5:3]) || is_div(op_i[5:3]),
                is_mul(op_i[2:0]) || is_div(op_i[2:0])};
    cur_op   = cur_q ? op_q[5:3]  : op_q[2:0];
    cur_a    = cur_q ? a_q[63:32] : a_q[31:0];
    cur_b    = cur_q ? b_q[63:32] : b_q[31:0];
    sel_done = is_mul(cur_op) ? mul_done_i : div_done_i;
    quo      = div_c_i[31:0];
    rem      = div_c_i[63:32];
    if (is_mul(cur_op)) begin
      fixed_res = (is_sgn(cur_op) && (cur_a[31] ^ cur_b[31])) ? (~mul_c_i + 64'd1) : mul_c_i;
    end else begin
      if (is_sgn(cur_op) && (cur_a[31] ^ cur_b[31])) quo = ~quo + 32'd1;
      if (is_sgn(cur_op) && cur_a[31])               rem = ~rem + 32'd1;
      fixed_res = {rem, quo};
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    pend_d   = pend_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hilo_d   = hilo_q;
    cnt_d    = cnt_q;
    wd_err_d = wd_err_q;
`ifdef MULDIV_FASTZERO_EN
    idle_op  = pend_in[1] ? op_i[5:3]  : op_i[2:0];
    idle_a   = pend_in[1] ? a_i[63:32] : a_i[31:0];
    idle_b   = pend_in[1] ? b_i[63:32] : b_i[31:0];
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pend_in != '0) begin
          op_d    = op_i;
          a_d     = a_i;
          b_d     = b_i;
          pend_d  = pend_in;
          cur_d   = pend_in[1];
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef MULDIV_FASTZERO_EN
          if (fast_zero(idle_op, idle_a, idle_b)) begin
            if (pend_in[1]) hilo_d[127:64] = '0;
            else            hilo_d[63:0]   = '0;
            if (pend_in == 2'b11) begin
              cur_d   = 1'b0;
              state_d = S_GAP;
            end else begin
              state_d = S_DONE;
            end
          end
`endif
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (sel_done || (cnt_q == CW'(WATCHDOG - 1))) begin
          if (cur_q) hilo_d[127:64] = sel_done ? fixed_res : '0;
          else       hilo_d[63:0]   = sel_done ? fixed_res : '0;
          if (!sel_done) wd_err_d = 1'b1;
          if (cur_q && pend_q[0]) begin
            cur_d   = 1'b0;
            state_d = S_GAP;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_GAP: begin
        cnt_d   = '0;
        state_d = S_RUN;
`ifdef MULDIV_FASTZERO_EN
        if (fast_zero(cur_op, cur_a, cur_b)) begin
          hilo_d[63:0] = '0;
          state_d      = S_DONE;
        end
`endif
      end
      S_DONE: begin
        if (!stall_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Flush discards any result or error that would have landed this cycle.
    if (flush_i) begin
      state_d  = S_IDLE;
      hilo_d   = hilo_q;
      wd_err_d = wd_err_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cur_q    <= 1'b0;
      pend_q   <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hilo_q   <= '0;
      cnt_q    <= '0;
      wd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      pend_q   <= pend_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hilo_q   <= hilo_d;
      cnt_q    <= cnt_d;
      wd_err_q <= wd_err_d;
    end
  end

  always_comb begin
    mul_valid_o = (state_q == S_RUN) && is_mul(cur_op);
    div_valid_o = (state_q == S_RUN) && is_div(cur_op);
    unit_a_o    = mag(cur_a, is_sgn(cur_op));
    unit_b_o    = mag(cur_b, is_sgn(cur_op));
    hilo_o      = hilo_q;
    hilo_vld_o  = (state_q == S_DONE) ? pend_q : '0;
    e_wait      = ((state_q == S_IDLE) && (pend_in != '0)) ||
                  (state_q == S_RUN) || (state_q == S_GAP);
    wd_err_o    = wd_err_q;
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched with behavioural multiplier/divider units and a result scoreboard.
module tb_muldiv_sched;

  localparam int unsigned WD = 16;
  localparam int unsigned KM = 3;
  localparam int unsigned KD = 4;

  logic         clk = 1'b0;
  logic         resetn;
  logic [5:0]   op_i;
  logic [63:0]  a_i, b_i;
  logic         flush_i, stall_i;
  logic         mul_valid_o, div_valid_o;
  logic [31:0]  unit_a_o, unit_b_o;
  logic         mul_done_i, div_done_i;
  logic [63:0]  mul_c_i, div_c_i;
  logic [127:0] hilo_o;
  logic [1:0]   hilo_vld_o;
  logic         e_wait, wd_err_o;

  muldiv_sched #(.WATCHDOG(WD)) dut (
    .clk(clk), .resetn(resetn), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .stall_i(stall_i),
    .mul_valid_o(mul_valid_o), .div_valid_o(div_valid_o),
    .unit_a_o(unit_a_o), .unit_b_o(unit_b_o),
    .mul_done_i(mul_done_i), .mul_c_i(mul_c_i),
    .div_done_i(div_done_i), .div_c_i(div_c_i),
    .hilo_o(hilo_o), .hilo_vld_o(hilo_vld_o), .e_wait(e_wait), .wd_err_o(wd_err_o)
  );

  always #5 clk = ~clk;

  // Behavioural units: done after KM/KD cycles of continuous valid, unsigned arithmetic.
  int unsigned mcnt = 0;
  int unsigned dcnt = 0;
  logic        mul_en;

  always @(posedge clk) begin
    mcnt <= mul_valid_o ? mcnt + 1 : 0;
    dcnt <= div_valid_o ? dcnt + 1 : 0;
  end

  assign mul_done_i = mul_en && mul_valid_o && (mcnt == KM - 1);
  assign mul_c_i    = {32'b0, unit_a_o} * {32'b0, unit_b_o};
  assign div_done_i = div_valid_o && (dcnt == KD - 1);
  assign div_c_i    = (unit_b_o == 32'd0) ? {unit_a_o, 32'hFFFF_FFFF}
                                          : {unit_a_o % unit_b_o, unit_a_o / unit_b_o};

  typedef struct { bit slot; logic [63:0] val; } exp_t;
  exp_t        sbq[$];
  logic [63:0] exp_hilo [2];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit slot, input logic [63:0] v);
    exp_t e;
    e.slot = slot;
    e.val  = v;
    sbq.push_back(e);
    exp_hilo[slot] = v;
  endtask

  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    int     q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ref_res = '0;
    case (op)
      3'd1: ref_res = sa * sb;
      3'd2: ref_res = {32'b0, a} * {32'b0, b};
      3'd3: begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        ref_res = {32'(r), 32'(q)};
      end
      3'd4: ref_res = {a % b, a / b};
      default: ref_res = '0;
    endcase
  endfunction

  task automatic run_group(input string tag,
                           input logic [2:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                           input logic [2:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                           output int lat, output int first_unit, output int mulcyc);
    logic [1:0]  ev;
    int          cyc;
    exp_t        e;
    logic [63:0] obs;
    ev = {(o1 >= 3'd1) && (o1 <= 3'd4), (o0 >= 3'd1) && (o0 <= 3'd4)};
    @(negedge clk);
    op_i = {o1, o0}; a_i = {a1, a0}; b_i = {b1, b0}; stall_i = 1'b1;
    #1;
    check({tag, " e_wait_issue"}, e_wait, 1);
    lat = 0; first_unit = 0; mulcyc = 0; cyc = 0;
    while (hilo_vld_o == 2'b00 && cyc < 200) begin
      if (e_wait) lat++;
      if (mul_valid_o) mulcyc++;
      if (first_unit == 0) first_unit = mul_valid_o ? 1 : (div_valid_o ? 2 : 0);
      @(negedge clk);
      op_i = '0;
      cyc++;
    end
    check({tag, " vld"}, hilo_vld_o, ev);
    check({tag, " e_wait_done"}, e_wait, 0);
    for (int s = 1; s >= 0; s--) begin
      if (ev[s]) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
        end else begin
          e   = sbq.pop_front();
          obs = (s == 1) ? hilo_o[127:64] : hilo_o[63:0];
          check({tag, (s == 1) ? " hilo1" : " hilo0"}, obs, e.val);
        end
      end
    end
    @(negedge clk);
    check({tag, " stall_hold"}, hilo_vld_o, ev);
    stall_i = 1'b0;
    @(negedge clk);
    check({tag, " consumed"}, hilo_vld_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, fu, mc;
    op_i = '0; a_i = '0; b_i = '0; flush_i = 1'b0; stall_i = 1'b0;
    mul_en = 1'b1; resetn = 1'b0;
    exp_hilo[0] = '0; exp_hilo[1] = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    check("rst e_wait", e_wait, 0);
    check("rst valids", {mul_valid_o, div_valid_o}, 0);
    check("rst hilo", hilo_o, 0);
    check("rst vld", hilo_vld_o, 0);
    check("rst wd_err", wd_err_o, 0);

    push_exp(1, 64'hFFFF_FFFF_FFFF_FFF1);
    run_group("t1_mult", 3'd1, 32'hFFFF_FFFD, 32'd5, 3'd0, 32'd0, 32'd0, lat, fu, mc);
    check("t1_latency", lat, KM + 1);

    push_exp(0, 64'hFFFF_FFFF_FFFF_FFFD);
    run_group("t2_div", 3'd0, 32'd0, 32'd0, 3'd3, 32'hFFFF_FFF9, 32'd2, lat, fu, mc);
    check("t2_latency", lat, KD + 1);
    push_exp(0, 64'h0000_0001_7FFF_FFFC);
    run_group("t2_divu", 3'd0, 32'd0, 32'd0, 3'd4, 32'hFFFF_FFF9, 32'd2, lat, fu, mc);

    push_exp(1, 64'h0000_0001_0000_0000);
    push_exp(0, 64'h0000_0002_0000_000E);
    run_group("t3_pair", 3'd2, 32'h0001_0000, 32'h0001_0000, 3'd4, 32'd100, 32'd7, lat, fu, mc);
    check("t3_slot1_first", fu, 1);

    push_exp(1, 64'h0000_0000_8000_0000);
    push_exp(0, 64'h4000_0000_0000_0000);
    run_group("min_int", 3'd3, 32'h8000_0000, 32'd1, 3'd1, 32'h8000_0000, 32'h8000_0000,
              lat, fu, mc);

    push_exp(1, ref_res(3'd1, 32'h1234_5678, 32'h9ABC_DEF0));
    push_exp(0, ref_res(3'd3, 32'hFFFF_FF9C, 32'd7));
    run_group("model_pair", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 3'd3, 32'hFFFF_FF9C, 32'd7,
              lat, fu, mc);

    push_exp(1, 64'h0000_0005_FFFF_FFFF);
    run_group("divu_by_zero", 3'd4, 32'd5, 32'd0, 3'd0, 32'd0, 32'd0, lat, fu, mc);

    // flush lands in the third RUN cycle, the same cycle the multiplier reports done
    @(negedge clk);
    op_i = {3'd1, 3'd0}; a_i = {32'd9, 32'd0}; b_i = {32'd9, 32'd0};
    @(negedge clk);
    op_i = '0;
    @(negedge clk);
    @(negedge clk);
    check("t4_run3_valid", mul_valid_o, 1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("t4_valids", {mul_valid_o, div_valid_o}, 0);
    check("t4_e_wait", e_wait, 0);
    check("t4_vld", hilo_vld_o, 0);
    check("t4_hilo_kept", hilo_o, {exp_hilo[1], exp_hilo[0]});
    @(negedge clk);
    check("t4_still_idle", hilo_vld_o, 0);

    push_exp(1, 64'h0);
    run_group("t6_fastzero", 3'd1, 32'd0, 32'd1234, 3'd0, 32'd0, 32'd0, lat, fu, mc);
`ifdef MULDIV_FASTZERO_EN
    check("t6_latency", lat, 1);
    check("t6_mul_cycles", mc, 0);
`else
    check("t6_latency", lat, KM + 1);
    check("t6_mul_cycles", mc, KM);
`endif

    @(negedge clk);
    op_i = {3'd0, 3'd4}; a_i = {32'd0, 32'd7}; b_i = {32'd0, 32'd2};
    @(negedge clk);
    op_i = '0;
    @(negedge clk);
    check("rstrun_valid", div_valid_o, 1);
    #1 resetn = 1'b0;
    #1;
    check("rstrun_valid_drop", div_valid_o, 0);
    check("rstrun_hilo", hilo_o, 0);
    exp_hilo[0] = '0; exp_hilo[1] = '0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rstrun_idle", e_wait, 0);

    mul_en = 1'b0;
    push_exp(1, 64'h0);
    run_group("t5_watchdog", 3'd1, 32'd3, 32'd5, 3'd0, 32'd0, 32'd0, lat, fu, mc);
    check("t5_latency", lat, WD + 1);
    check("t5_wd_err", wd_err_o, 1);
    mul_en = 1'b1;

    push_exp(0, 64'd35);
    run_group("wd_sticky", 3'd0, 32'd0, 32'd0, 3'd2, 32'd5, 32'd7, lat, fu, mc);
    check("wd_err_sticky", wd_err_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
